// File: rtl/sort8_feeder.sv
// Stream-to-vector front end for the 8-lane sorting network.
// Keys are packed into N-lane frames held in two ping-pong banks; the read bank drives the sorter.
module sort8_feeder #(
    parameter int             W   = 32,
    parameter int             N   = 8,
    parameter logic [W-1:0]   PAD = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [N*W-1:0]   out_data,
    output logic [3:0]       out_count,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [W-1:0] r_lane [2][N];
    logic [3:0]   r_cnt  [2];
    logic [1:0]   r_full;
    logic         r_wb;
    logic         r_rb;
    logic [2:0]   r_idx;

    logic         w_acc;
    logic         w_take;
    logic         w_close;

    assign in_ready  = !r_full[r_wb];
    assign out_valid = r_full[r_rb];
    assign out_count = r_cnt[r_rb];

    assign w_acc   = in_valid && in_ready;
    assign w_take  = out_valid && out_ready;
    assign w_close = w_acc && (in_last || (r_idx == 3'(N - 1)));

    // Output vector is a pure register mux, so the sorter never sees input-side glitches.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < N; k++) begin
            out_data[k*W +: W] = r_lane[r_rb][k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= '0;
            r_wb   <= 1'b0;
            r_rb   <= 1'b0;
            r_idx  <= 3'd0;
            for (int b = 0; b < 2; b++) begin
                r_cnt[b] <= 4'd0;
                for (int k = 0; k < N; k++) begin
                    r_lane[b][k] <= PAD;
                end
            end
        end else begin
            if (w_take) begin
                r_full[r_rb] <= 1'b0;
                r_rb         <= !r_rb;
            end
            if (w_acc) begin
                // First beat pre-pads the rest of the bank so short frames never carry stale keys.
                if (r_idx == 3'd0) begin
                    for (int k = 1; k < N; k++) begin
                        r_lane[r_wb][k] <= PAD;
                    end
                end
                r_lane[r_wb][r_idx] <= in_data;
                if (w_close) begin
                    r_cnt[r_wb]  <= {1'b0, r_idx} + 4'd1;
                    r_full[r_wb] <= 1'b1;
                    r_wb         <= !r_wb;
                    r_idx        <= 3'd0;
                end else begin
                    r_idx <= r_idx + 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sort8_feeder.sv
// Bench for sort8_feeder: directed scenarios plus random traffic against a frame-queue model.
module tb_sort8_feeder;
    localparam int           W   = 32;
    localparam int           N   = 8;
    localparam logic [W-1:0] PAD = 32'hFFFF_FFFF;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [N*W-1:0] out_data;
    logic [3:0]     out_count;
    logic           out_valid;
    logic           out_ready;

    sort8_feeder #(.W(W), .N(N), .PAD(PAD)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] data;
        logic [3:0]     cnt;
    } frame_t;

    int           errors = 0;
    int           checks = 0;
    frame_t       q[$];
    logic [W-1:0] part[$];
    bit           last_acc;

    task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] seq_frame(input logic [W-1:0] base);
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = base + W'(k);
        return v;
    endfunction

    // One clock: compare DUT against the model, drive inputs, advance the model, cross the edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic l,
                        input logic ord, input logic r);
        bit     acc;
        bit     take;
        frame_t f;
        check("in_ready", in_ready, q.size() < 2);
        check("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            check("out_data", out_data, q[0].data);
            check("out_count", out_count, q[0].cnt);
        end
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ord;
        rst       = r;
        last_acc  = 1'b0;
        if (r) begin
            q.delete();
            part.delete();
        end else begin
            acc  = v && (q.size() < 2);
            take = ord && (q.size() > 0);
            if (take) q.pop_front();
            if (acc) begin
                last_acc = 1'b1;
                part.push_back(d);
                if (l || part.size() == N) begin
                    f.data = {N{PAD}};
                    for (int k = 0; k < part.size(); k++) f.data[k*W +: W] = part[k];
                    f.cnt = 4'(part.size());
                    q.push_back(f);
                    part.delete();
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] key;
        int           n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_count", out_count, 4'd0);
        check("rst_out_data", out_data, {N{PAD}});

        // Keys 1..8 back-to-back, frame appears one cycle after the 8th acceptance.
        for (int i = 1; i <= N; i++) step(1'b1, W'(i), 1'b0, 1'b1, 1'b0);
        check("t1_valid", out_valid, 1'b1);
        check("t1_data", out_data, seq_frame(32'd1));
        check("t1_count", out_count, 4'd8);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("t1_one_cycle", out_valid, 1'b0);

        // Short frames padded, no leftovers.
        step(1'b1, 32'hA, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'hC, 1'b1, 1'b1, 1'b0);
        check("t2_data3", out_data, {{5{PAD}}, 32'hC, 32'hB, 32'hA});
        check("t2_count3", out_count, 4'd3);
        step(1'b1, 32'h5, 1'b1, 1'b1, 1'b0);
        check("t2_data1", out_data, {{7{PAD}}, 32'h5});
        check("t2_count1", out_count, 4'd1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Backpressure: two frames buffered, rejected keys never appear.
        key = 32'd100;
        n   = 0;
        for (int c = 0; c < 40 && n < 16; c++) begin
            step(1'b1, key, 1'b0, 1'b0, 1'b0);
            if (last_acc) begin key++; n++; end
        end
        check("t3_ready_low", in_ready, 1'b0);
        check("t3_hold", out_data, seq_frame(32'd100));
        for (int c = 0; c < 3; c++) step(1'b1, 32'hDEAD_0000 + W'(c), 1'b0, 1'b0, 1'b0);
        check("t3_hold2", out_data, seq_frame(32'd100));
        check("t3_ready_low2", in_ready, 1'b0);
        for (int c = 0; c < 60 && (n < 24 || q.size() > 0); c++) begin
            step(n < 24, key, 1'b0, 1'b1, 1'b0);
            if (last_acc) begin key++; n++; end
        end
        check("t3_drained", out_valid, 1'b0);

        // Continuous stream with out_ready toggling each cycle.
        key = 32'd1000;
        n   = 0;
        for (int c = 0; c < 200 && (n < 32 || q.size() > 0); c++) begin
            step(n < 32, key, 1'b0, (c % 2) == 0, 1'b0);
            if (last_acc) begin key++; n++; end
        end
        check("t4_drained", out_valid, 1'b0);

        // Reset mid-frame with a full frame held.
        for (int i = 0; i < N; i++) step(1'b1, 32'd200 + W'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'd300 + W'(i), 1'b0, 1'b0, 1'b0);
        check("t5_held", out_valid, 1'b1);
        step(1'b1, 32'h999, 1'b0, 1'b0, 1'b1);
        check("t5_rst_valid", out_valid, 1'b0);
        check("t5_rst_ready", in_ready, 1'b1);
        check("t5_rst_data", out_data, {N{PAD}});
        check("t5_rst_count", out_count, 4'd0);
        step(1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
        check("t5_lane0", out_data, {{7{PAD}}, 32'h77});
        check("t5_count", out_count, 4'd1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Random traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            step(($urandom % 4) != 0, $urandom, ($urandom % 5) == 0,
                 ($urandom % 3) != 0, ($urandom % 97) == 0);
        end
        for (int c = 0; c < 6; c++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("final_idle", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
